// File: rtl/dmem_mmio.sv
// Data-side responder for the single-cycle core: word RAM plus an MMIO page with
// a cycle counter, an output FIFO, a status register and a halt register.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned RamAw  = $clog2(RAM_WORDS);
  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = FifoAw + 1;

  localparam logic [5:0] SelCycle  = 6'h00;
  localparam logic [5:0] SelTx     = 6'h01;
  localparam logic [5:0] SelStatus = 6'h02;
  localparam logic [5:0] SelHalt   = 6'h03;

  logic             is_mmio;
  logic [5:0]       reg_sel;
  logic [RamAw-1:0] ram_idx;
  logic             unused_a;

  assign is_mmio  = (a[31:8] == 24'hFF_FFFF);
  assign reg_sel  = a[7:2];
  assign ram_idx  = a[RamAw+1:2];
  assign unused_a = ^a[1:0];

  // RAM: no reset, upper address bits ignored so the array aliases.
  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we && !is_mmio) begin
      mem[ram_idx] <= wd;
    end
  end

  logic [31:0]       cycle_q;
  logic [FifoAw-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              halt_q;
  logic [31:0]       halt_code_q;
  logic [31:0]       fifo_mem [FIFO_DEPTH];

  logic full, empty, pop, push_req, push, ovf_set, ovf_clr, halt_we;

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && out_ready;
  assign push_req = we && is_mmio && (reg_sel == SelTx);
  // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = we && is_mmio && (reg_sel == SelStatus) && wd[2];
  assign halt_we  = we && is_mmio && (reg_sel == SelHalt);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FifoAw'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FifoAw'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (halt_we) begin
        halt_q      <= 1'b1;
        halt_code_q <= wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wd;
    end
  end

  assign out_valid = !empty;
  assign out_data  = fifo_mem[rd_ptr_q];
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

  always_comb begin
    rd = '0;
    if (is_mmio) begin
      case (reg_sel)
        SelCycle:  rd = cycle_q;
        SelStatus: rd = {16'b0, 8'(count_q), 5'b0, ovf_q, full, empty};
        SelHalt:   rd = {31'b0, halt_q};
        default:   rd = '0;
      endcase
    end else begin
      rd = mem[ram_idx];
    end
  end

endmodule
